// File: rtl/msdap_pkg.sv
// Shared types and defaults for the MSDAP output path.
package msdap_pkg;
  localparam int OUT_WORD_W = 40;
  typedef enum logic {IDLE, SHIFT} outser_state_t;
endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position down-counter shared by both serializer channels.
// Latency: count updates one edge after load/dec; zero is decoded straight from the count register.
module serial_bit_counter
  import msdap_pkg::*;
#(
  parameter int WIDTH = OUT_WORD_W,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (load)
      count <= LAST;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/output_serializer.sv
// Stereo parallel-to-serial transmitter; first bit appears one edge after load, WIDTH bits per frame.
// Reload on the last bit is seamless; loads mid-frame are dropped and set sticky overrun. OUTSER_LSB_FIRST_EN reverses bit order.
module output_serializer
  import msdap_pkg::*;
#(
  parameter int WIDTH = OUT_WORD_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] dataL,
  input  logic [WIDTH-1:0] dataR,
  output logic             OutputL,
  output logic             OutputR,
  output logic             OutReady,
  output logic             busy,
  output logic             overrun
);
  outser_state_t    state;
  logic [WIDTH-1:0] sh_l;
  logic [WIDTH-1:0] sh_r;
  logic             cnt_zero;
  logic             in_shift;
  logic             accept;

  assign in_shift = (state == SHIFT);
  // A new pair is taken when idle or while the last bit of the current frame is on the pins.
  assign accept   = load && (!in_shift || cnt_zero);

  serial_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .clear (clear),
    .load  (accept),
    .dec   (in_shift),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= IDLE;
      sh_l     <= '0;
      sh_r     <= '0;
      OutputL  <= 1'b0;
      OutputR  <= 1'b0;
      OutReady <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load && in_shift && !cnt_zero)
        overrun <= 1'b1;
      if (accept) begin
        state    <= SHIFT;
        OutReady <= 1'b1;
`ifdef OUTSER_LSB_FIRST_EN
        OutputL  <= dataL[0];
        OutputR  <= dataR[0];
        sh_l     <= dataL >> 1;
        sh_r     <= dataR >> 1;
`else
        OutputL  <= dataL[WIDTH-1];
        OutputR  <= dataR[WIDTH-1];
        sh_l     <= dataL << 1;
        sh_r     <= dataR << 1;
`endif
      end else if (in_shift && !cnt_zero) begin
`ifdef OUTSER_LSB_FIRST_EN
        OutputL  <= sh_l[0];
        OutputR  <= sh_r[0];
        sh_l     <= sh_l >> 1;
        sh_r     <= sh_r >> 1;
`else
        OutputL  <= sh_l[WIDTH-1];
        OutputR  <= sh_r[WIDTH-1];
        sh_l     <= sh_l << 1;
        sh_r     <= sh_r << 1;
`endif
      end else begin
        state    <= IDLE;
        sh_l     <= '0;
        sh_r     <= '0;
        OutputL  <= 1'b0;
        OutputR  <= 1'b0;
        OutReady <= 1'b0;
      end
    end
  end

  assign busy = OutReady;
endmodule

// File: tb/tb_output_serializer.sv
// Bench for output_serializer: directed frames plus random traffic against a bit-queue model.
module tb_output_serializer;
  localparam int W = msdap_pkg::OUT_WORD_W;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] dataL = '0;
  logic [W-1:0] dataR = '0;
  logic         OutputL, OutputR, OutReady, busy, overrun;

  int n_asserts = 0;
  int n_fail = 0;

  // Model: the bits still to appear on each pin; element 0 is the bit currently shown.
  logic ql[$];
  logic qr[$];
  logic exp_ovr = 1'b0;

  output_serializer #(.WIDTH(W)) dut (
    .clk      (clk),
    .clear    (clear),
    .load     (load),
    .dataL    (dataL),
    .dataR    (dataR),
    .OutputL  (OutputL),
    .OutputR  (OutputR),
    .OutReady (OutReady),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge(input logic ld, input logic clr,
                                     input logic [W-1:0] dl, input logic [W-1:0] dr);
    if (clr) begin
      ql.delete();
      qr.delete();
      exp_ovr = 1'b0;
    end else begin
      if (ql.size() > 0) begin
        void'(ql.pop_front());
        void'(qr.pop_front());
      end
      if (ld) begin
        if (ql.size() == 0) begin
          for (int i = 0; i < W; i++) begin
`ifdef OUTSER_LSB_FIRST_EN
            ql.push_back(dl[i]);
            qr.push_back(dr[i]);
`else
            ql.push_back(dl[W-1-i]);
            qr.push_back(dr[W-1-i]);
`endif
          end
        end else begin
          exp_ovr = 1'b1;
        end
      end
    end
  endfunction

  task automatic step(input logic ld, input logic clr,
                      input logic [W-1:0] dl, input logic [W-1:0] dr);
    logic rdy;
    load  = ld;
    clear = clr;
    dataL = dl;
    dataR = dr;
    @(posedge clk);
    model_edge(ld, clr, dl, dr);
    #1;
    rdy = (ql.size() != 0);
    check("outready", 64'(OutReady), 64'(rdy));
    check("busy",     64'(busy),     64'(rdy));
    check("outl",     64'(OutputL),  64'(rdy ? ql[0] : 1'b0));
    check("outr",     64'(OutputR),  64'(rdy ? qr[0] : 1'b0));
    check("overrun",  64'(overrun),  64'(exp_ovr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int rdy_cycles;
    logic [W-1:0] wa;
    logic [W-1:0] wb;

    // Reset held with load asserted: nothing may start.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '1, '1);
    idle(2);
    check("reset_idle", 64'(OutReady), 64'd0);

    // Single frame with only the end bits of the left word set.
    wa = '0; wa[W-1] = 1'b1; wa[0] = 1'b1;
    step(1'b1, 1'b0, wa, '0);
    rdy_cycles = int'(OutReady);
    for (int i = 0; i < W + 4; i++) begin
      step(1'b0, 1'b0, '0, '0);
      rdy_cycles += int'(OutReady);
    end
    check("single_len", 64'(rdy_cycles), 64'(W));

    // Back-to-back: second word loaded on the last bit cycle.
    for (int i = 0; i < W; i++) begin
      wa[i] = (i % 2 == 1);
      wb[i] = (i % 2 == 0);
    end
    step(1'b1, 1'b0, wa, ~wa);
    rdy_cycles = 1;
    for (int i = 1; i < W; i++) begin
      step(1'b0, 1'b0, '0, '0);
      rdy_cycles += int'(OutReady);
    end
    step(1'b1, 1'b0, wb, ~wb);
    rdy_cycles += int'(OutReady);
    for (int i = 1; i < W + 3; i++) begin
      step(1'b0, 1'b0, '0, '0);
      rdy_cycles += int'(OutReady);
    end
    check("b2b_len", 64'(rdy_cycles), 64'(2 * W));
    check("b2b_no_overrun", 64'(overrun), 64'd0);

    // Overrun: load while bit 10 is on the pins.
    wa = W'(64'hDEAD_BEEF_CAFE_F00D);
    step(1'b1, 1'b0, wa, ~wa);
    idle(9);
    step(1'b1, 1'b0, ~wa, wa);
    idle(W + 3);
    check("overrun_sticky", 64'(overrun), 64'd1);

    // Mid-frame clear at bit 20, then a fresh frame two cycles later.
    step(1'b1, 1'b0, wa, wa);
    idle(19);
    step(1'b0, 1'b1, '0, '0);
    check("clear_overrun", 64'(overrun), 64'd0);
    idle(1);
    step(1'b1, 1'b0, ~wa, wa);
    idle(W + 2);

    // Single low bit: with LSB-first it is the first bit, else the last.
    wa = '0; wa[0] = 1'b1;
    step(1'b1, 1'b0, wa, '0);
    idle(W + 1);

    // Random traffic, biased toward loads on the last bit and the odd clear.
    for (int c = 0; c < 3000; c++) begin
      logic ld;
      logic cl;
      wa = W'({$urandom, $urandom});
      wb = W'({$urandom, $urandom});
      ld = (ql.size() == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
      cl = ($urandom_range(0, 399) == 0);
      step(ld, cl, wa, wb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
